// File: rtl/pcpu_dec_pkg.sv
// ============================================================================
//  pcpu_dec_pkg
//  Opcodes, ALU modes, jump condition codes and decoder states.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pcpu_dec_pkg;

    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_MOV = 7'h01;
    localparam logic [6:0] OP_LDD = 7'h02;
    localparam logic [6:0] OP_LDO = 7'h03;
    localparam logic [6:0] OP_LDI = 7'h04;
    localparam logic [6:0] OP_STD = 7'h05;
    localparam logic [6:0] OP_STO = 7'h06;
    localparam logic [6:0] OP_ADD = 7'h07;
    localparam logic [6:0] OP_ADI = 7'h08;
    localparam logic [6:0] OP_ADC = 7'h09;
    localparam logic [6:0] OP_SUB = 7'h0A;
    localparam logic [6:0] OP_SUC = 7'h0B;
    localparam logic [6:0] OP_CMP = 7'h0C;
    localparam logic [6:0] OP_CMI = 7'h0D;
    localparam logic [6:0] OP_JMP = 7'h0E;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_PASS_L = 4'b1001;
    localparam logic [3:0] ALU_PASS_R = 4'b1010;

    localparam logic [3:0] JC_CA = 4'd1;
    localparam logic [3:0] JC_EQ = 4'd2;
    localparam logic [3:0] JC_LT = 4'd3;
    localparam logic [3:0] JC_GT = 4'd4;
    localparam logic [3:0] JC_LE = 4'd5;
    localparam logic [3:0] JC_GE = 4'd6;
    localparam logic [3:0] JC_NE = 4'd7;
    localparam logic [3:0] JC_OV = 4'd8;
    localparam logic [3:0] JC_NV = 4'd9;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LDD) || (op == OP_LDO) || (op == OP_STD) || (op == OP_STO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_jcond.sv
// ============================================================================
//  decoder_jcond
//  Jump condition evaluation: condition code + Z/C/N/V flags -> jmp_en.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module decoder_jcond
    import pcpu_dec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       jmp_en
);

    logic z, c, n, v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        jmp_en = 1'b1;
        case (cond)
            JC_CA:   jmp_en = c;
            JC_EQ:   jmp_en = z;
            JC_LT:   jmp_en = n;
            JC_GT:   jmp_en = ~(n | z);
            JC_LE:   jmp_en = n | z;
            JC_GE:   jmp_en = ~n;
            JC_NE:   jmp_en = ~z;
            JC_OV:   jmp_en = v;
            JC_NV:   jmp_en = ~v;
            default: jmp_en = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// ============================================================================
//  decoder_seq
//  Handshaked instruction decoder with IR, RAM wait-state stretching and jumps.
//  Optional feature macro: DECODER_SEQ_ILLEGAL_TRAP_EN (illegal-opcode trap).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module decoder_seq
    import pcpu_dec_pkg::*;
#(
    parameter  int REG_AW  = 3,
    parameter  int FLAGS_W = 5,
    localparam int REG_CNT = 2 ** REG_AW,
    localparam int INSTR_W = 7 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [FLAGS_W-1:0] flags,
    input  logic               mem_ack,
    output logic               pc_inc,
    output logic               pc_ie,
    output logic               reg_in_mux_ctl,
    output logic               alu_r_mux_ctl,
    output logic               alu_cin,
    output logic [3:0]         alu_mode,
    output logic [REG_AW-1:0]  reg_l_ctl,
    output logic [REG_AW-1:0]  reg_r_ctl,
    output logic [REG_CNT-1:0] gp_reg_ie,
    output logic               alu_flags_ie,
    output logic               ram_read,
    output logic               ram_write,
    output logic               busy,
    output logic               trap
);

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic               live;

    logic [6:0]        op;
    logic [REG_AW-1:0] tg, fo, so;
    logic              active, mem_op, retire, illegal, jmp_en, taken, load;
    logic              wr_reg, wr_flags, rmux, inmux, cin;
    logic [3:0]        mode;

    assign op = ir[6:0];
    assign tg = ir[7 +: REG_AW];
    assign fo = ir[7 + REG_AW +: REG_AW];
    assign so = ir[7 + 2 * REG_AW +: REG_AW];

    generate
        if (FLAGS_W > 4) begin : g_spare_flags
            logic unused_flags;
            assign unused_flags = ^flags[FLAGS_W-1:4];
        end
    endgenerate

    decoder_jcond u_jcond (
        .cond   (ir[10:7]),
        .flags  (flags[3:0]),
        .jmp_en (jmp_en)
    );

    assign active = (state == ST_EXEC) || (state == ST_MEM);
    assign mem_op = is_mem_op(op);
    assign retire = active && (!mem_op || mem_ack);

`ifdef DECODER_SEQ_ILLEGAL_TRAP_EN
    assign illegal = active && (op > OP_JMP);
`else
    assign illegal = 1'b0;
`endif

    assign taken = retire && (op == OP_JMP) && jmp_en;

    always_comb begin
        wr_reg   = 1'b0;
        wr_flags = 1'b0;
        mode     = ALU_ADD;
        rmux     = 1'b0;
        inmux    = 1'b0;
        cin      = 1'b0;
        case (op)
            OP_MOV: begin wr_reg = 1'b1; mode = ALU_PASS_L; end
            OP_LDD: begin wr_reg = 1'b1; inmux = 1'b1; rmux = 1'b1; mode = ALU_PASS_R; end
            OP_LDO: begin wr_reg = 1'b1; inmux = 1'b1; rmux = 1'b1; end
            OP_LDI: begin wr_reg = 1'b1; rmux = 1'b1; mode = ALU_PASS_R; end
            OP_STD: begin rmux = 1'b1; mode = ALU_PASS_R; end
            OP_STO: begin rmux = 1'b1; end
            OP_ADD: begin wr_reg = 1'b1; wr_flags = 1'b1; end
            OP_ADI: begin wr_reg = 1'b1; wr_flags = 1'b1; rmux = 1'b1; end
            OP_ADC: begin wr_reg = 1'b1; wr_flags = 1'b1; cin = flags[FLAG_C]; end
            OP_SUB: begin wr_reg = 1'b1; wr_flags = 1'b1; mode = ALU_SUB; end
            OP_SUC: begin wr_reg = 1'b1; wr_flags = 1'b1; mode = ALU_SUB; cin = flags[FLAG_C]; end
            OP_CMP: begin wr_flags = 1'b1; mode = ALU_SUB; end
            OP_CMI: begin wr_flags = 1'b1; mode = ALU_SUB; rmux = 1'b1; end
            OP_JMP: begin rmux = 1'b1; mode = ALU_PASS_R; end
            default: ;
        endcase
    end

    // Controls are only meaningful while an instruction occupies the IR.
    assign alu_mode       = active ? mode  : 4'b0000;
    assign alu_r_mux_ctl  = active && rmux;
    assign reg_in_mux_ctl = active && inmux;
    assign alu_cin        = active && cin;
    assign reg_l_ctl      = active ? fo : '0;
    assign reg_r_ctl      = active ? so : '0;
    assign ram_read       = active && ((op == OP_LDD) || (op == OP_LDO));
    assign ram_write      = active && ((op == OP_STD) || (op == OP_STO));

    assign gp_reg_ie    = (retire && wr_reg) ? (REG_CNT'(1) << tg) : '0;
    assign alu_flags_ie = retire && wr_flags;
    assign pc_ie        = taken;
    assign pc_inc       = retire && !taken && !illegal;
    assign trap         = retire && illegal;
    assign busy         = (state != ST_IDLE);

    // A taken jump or trap refuses the next word: fetch is redirected.
    assign instr_ready = live && ((state == ST_IDLE) || (retire && !taken && !illegal));
    assign load        = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ir    <= '0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        ir    <= instr;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC, ST_MEM: begin
                    if (retire) begin
                        if (load) begin
                            ir    <= instr;
                            state <= ST_EXEC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= ST_MEM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// ============================================================================
//  tb_decoder_seq
//  Self-checking bench: vector table with a retire scoreboard plus corner cases.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decoder_seq;

    typedef struct packed {
        logic [7:0] reg_ie;
        logic       inc;
        logic       ie;
        logic       fie;
        logic       trap;
        logic       rdy;
        logic [3:0] mode;
        logic       rmux;
        logic       inmux;
        logic       cin;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  fl;
        int          waits;
        exp_t        e;
        int          rd;
        int          wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [4:0]  flags = '0;
    logic        mem_ack = 1'b0;
    logic        instr_ready, pc_inc, pc_ie, reg_in_mux_ctl, alu_r_mux_ctl, alu_cin;
    logic [3:0]  alu_mode;
    logic [2:0]  reg_l_ctl, reg_r_ctl;
    logic [7:0]  gp_reg_ie;
    logic        alu_flags_ie, ram_read, ram_write, busy, trap;

    logic [18:0] instr4 = '0;
    logic        instr_valid4 = 1'b0;
    logic        instr_ready4, pc_inc4, pc_ie4, reg_in_mux_ctl4, alu_r_mux_ctl4, alu_cin4;
    logic [3:0]  alu_mode4;
    logic [3:0]  reg_l_ctl4, reg_r_ctl4;
    logic [15:0] gp_reg_ie4;
    logic        alu_flags_ie4, ram_read4, ram_write4, busy4, trap4;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    vec_t vecs[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    decoder_seq #(.REG_AW(3), .FLAGS_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flags(flags), .mem_ack(mem_ack),
        .pc_inc(pc_inc), .pc_ie(pc_ie), .reg_in_mux_ctl(reg_in_mux_ctl),
        .alu_r_mux_ctl(alu_r_mux_ctl), .alu_cin(alu_cin), .alu_mode(alu_mode),
        .reg_l_ctl(reg_l_ctl), .reg_r_ctl(reg_r_ctl), .gp_reg_ie(gp_reg_ie),
        .alu_flags_ie(alu_flags_ie), .ram_read(ram_read), .ram_write(ram_write),
        .busy(busy), .trap(trap)
    );

    decoder_seq #(.REG_AW(4), .FLAGS_W(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr4), .instr_valid(instr_valid4),
        .instr_ready(instr_ready4), .flags(flags), .mem_ack(mem_ack),
        .pc_inc(pc_inc4), .pc_ie(pc_ie4), .reg_in_mux_ctl(reg_in_mux_ctl4),
        .alu_r_mux_ctl(alu_r_mux_ctl4), .alu_cin(alu_cin4), .alu_mode(alu_mode4),
        .reg_l_ctl(reg_l_ctl4), .reg_r_ctl(reg_r_ctl4), .gp_reg_ie(gp_reg_ie4),
        .alu_flags_ie(alu_flags_ie4), .ram_read(ram_read4), .ram_write(ram_write4),
        .busy(busy4), .trap(trap4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] tg,
                                       input logic [2:0] fo, input logic [2:0] so);
        return {so, fo, tg, op};
    endfunction

    function automatic logic [15:0] mkj(input logic [3:0] c);
        return mk(7'h0E, c[2:0], {2'b00, c[3]}, 3'd0);
    endfunction

    function automatic exp_t ex(input logic [7:0] r, input logic inc, input logic ie,
                                input logic fie, input logic tr, input logic [3:0] m,
                                input logic rm, input logic im, input logic ci);
        exp_t e;
        e.reg_ie = r; e.inc = inc; e.ie = ie; e.fie = fie; e.trap = tr;
        e.rdy = !ie && !tr; e.mode = m; e.rmux = rm; e.inmux = im; e.cin = ci;
        return e;
    endfunction

    task automatic add_vec(input logic [15:0] ins, input logic [4:0] fl, input int waits,
                           input exp_t e, input int rd, input int wr);
        vec_t v;
        v.ins = ins; v.fl = fl; v.waits = waits; v.e = e; v.rd = rd; v.wr = wr;
        vecs.push_back(v);
    endtask

    // Retire scoreboard: every pc_inc/pc_ie/trap cycle consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pc_inc || pc_ie || trap) begin
                if (sb.size() == 0) begin
                    chk("retire_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("retire_ctl",
                        {12'd0, gp_reg_ie, pc_inc, pc_ie, alu_flags_ie, trap, instr_ready,
                         alu_mode, alu_r_mux_ctl, reg_in_mux_ctl, alu_cin},
                        {12'd0, mon_e});
                end
            end else if (gp_reg_ie != 8'd0 || alu_flags_ie) begin
                chk("write_outside_retire", {23'd0, gp_reg_ie, alu_flags_ie}, 32'd0);
            end
        end
    end

    // Offer one instruction from IDLE and walk it through its wait states.
    task automatic send(input vec_t v);
        int guard = 0;
        int rd = 0;
        int wr = 0;
        flags = v.fl;
        instr = v.ins;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
        sb.push_back(v.e);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        mem_ack = (v.waits == 0);
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge clk);
            rd += int'(ram_read);
            wr += int'(ram_write);
            @(posedge clk);
            #1 mem_ack = (k + 1 == v.waits);
        end
        mem_ack = 1'b0;
        chk("ram_read_cycles", rd, v.rd);
        chk("ram_write_cycles", wr, v.wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t jt, jn, e_ill;
        jt = ex(8'h00, 0, 1, 0, 0, 4'b1010, 1, 0, 0);
        jn = ex(8'h00, 1, 0, 0, 0, 4'b1010, 1, 0, 0);
`ifdef DECODER_SEQ_ILLEGAL_TRAP_EN
        e_ill = ex(8'h00, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
`else
        e_ill = ex(8'h00, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
`endif
        add_vec(mk(7'h00, 0, 0, 0), 5'b00000, 0, ex(8'h00, 1, 0, 0, 0, 4'b0000, 0, 0, 0), 0, 0);
        add_vec(mk(7'h01, 3, 5, 0), 5'b00000, 0, ex(8'h08, 1, 0, 0, 0, 4'b1001, 0, 0, 0), 0, 0);
        add_vec(mk(7'h02, 5, 0, 0), 5'b00000, 0, ex(8'h20, 1, 0, 0, 0, 4'b1010, 1, 1, 0), 1, 0);
        add_vec(mk(7'h03, 5, 2, 0), 5'b00000, 3, ex(8'h20, 1, 0, 0, 0, 4'b0000, 1, 1, 0), 4, 0);
        add_vec(mk(7'h04, 2, 0, 0), 5'b00000, 0, ex(8'h04, 1, 0, 0, 0, 4'b1010, 1, 0, 0), 0, 0);
        add_vec(mk(7'h05, 0, 1, 0), 5'b00000, 2, ex(8'h00, 1, 0, 0, 0, 4'b1010, 1, 0, 0), 0, 3);
        add_vec(mk(7'h06, 0, 1, 2), 5'b00000, 1, ex(8'h00, 1, 0, 0, 0, 4'b0000, 1, 0, 0), 0, 2);
        add_vec(mk(7'h07, 1, 2, 3), 5'b00000, 0, ex(8'h02, 1, 0, 1, 0, 4'b0000, 0, 0, 0), 0, 0);
        add_vec(mk(7'h08, 4, 1, 0), 5'b00000, 0, ex(8'h10, 1, 0, 1, 0, 4'b0000, 1, 0, 0), 0, 0);
        add_vec(mk(7'h09, 6, 1, 2), 5'b00010, 0, ex(8'h40, 1, 0, 1, 0, 4'b0000, 0, 0, 1), 0, 0);
        add_vec(mk(7'h0A, 7, 1, 2), 5'b00010, 0, ex(8'h80, 1, 0, 1, 0, 4'b0001, 0, 0, 0), 0, 0);
        add_vec(mk(7'h0B, 0, 1, 2), 5'b00010, 0, ex(8'h01, 1, 0, 1, 0, 4'b0001, 0, 0, 1), 0, 0);
        add_vec(mk(7'h0B, 0, 1, 2), 5'b00000, 0, ex(8'h01, 1, 0, 1, 0, 4'b0001, 0, 0, 0), 0, 0);
        add_vec(mk(7'h0C, 0, 1, 2), 5'b00000, 0, ex(8'h00, 1, 0, 1, 0, 4'b0001, 0, 0, 0), 0, 0);
        add_vec(mk(7'h0D, 0, 1, 0), 5'b00000, 0, ex(8'h00, 1, 0, 1, 0, 4'b0001, 1, 0, 0), 0, 0);
        add_vec(mkj(4'd2),  5'b00001, 0, jt, 0, 0);
        add_vec(mkj(4'd2),  5'b00000, 0, jn, 0, 0);
        add_vec(mkj(4'd1),  5'b00010, 0, jt, 0, 0);
        add_vec(mkj(4'd1),  5'b00001, 0, jn, 0, 0);
        add_vec(mkj(4'd3),  5'b00100, 0, jt, 0, 0);
        add_vec(mkj(4'd4),  5'b00000, 0, jt, 0, 0);
        add_vec(mkj(4'd4),  5'b00001, 0, jn, 0, 0);
        add_vec(mkj(4'd5),  5'b00100, 0, jt, 0, 0);
        add_vec(mkj(4'd5),  5'b00000, 0, jn, 0, 0);
        add_vec(mkj(4'd6),  5'b00100, 0, jn, 0, 0);
        add_vec(mkj(4'd7),  5'b00000, 0, jt, 0, 0);
        add_vec(mkj(4'd7),  5'b00001, 0, jn, 0, 0);
        add_vec(mkj(4'd8),  5'b01000, 0, jt, 0, 0);
        add_vec(mkj(4'd9),  5'b01000, 0, jn, 0, 0);
        add_vec(mkj(4'd0),  5'b00000, 0, jt, 0, 0);
        add_vec(mkj(4'd15), 5'b00000, 0, jt, 0, 0);
        add_vec(mk(7'h20, 0, 0, 0), 5'b00000, 0, e_ill, 0, 0);

        // Reset state, then readiness only after release.
        #2;
        chk("reset_outputs",
            {20'd0, instr_ready, busy, pc_inc, pc_ie, ram_read, ram_write, trap, gp_reg_ie[0],
             alu_flags_ie, alu_mode[0], alu_r_mux_ctl, reg_in_mux_ctl}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", {30'd0, instr_ready, busy}, 32'd2);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

        // add r1,r2,r3 then adi r4,r1 back-to-back with valid held.
        instr = mk(7'h07, 1, 2, 3);
        instr_valid = 1'b1;
        flags = '0;
        sb.push_back(ex(8'h02, 1, 0, 1, 0, 4'b0000, 0, 0, 0));
        sb.push_back(ex(8'h10, 1, 0, 1, 0, 4'b0000, 1, 0, 0));
        @(posedge clk);
        #1 instr = mk(7'h08, 4, 1, 0);
        @(negedge clk);
        chk("b2b_first", {22'd0, gp_reg_ie, pc_inc, instr_ready}, {22'd0, 8'h02, 2'b11});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second", {23'd0, gp_reg_ie, pc_inc}, {23'd0, 8'h10, 1'b1});
        @(posedge clk);
        #1;

        // Reset while a store waits in MEM.
        instr = mk(7'h05, 0, 2, 0);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mem_pending", {30'd0, ram_write, busy}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid_mem", {29'd0, ram_write, busy, instr_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_mem_reset", {30'd0, instr_ready, busy}, 32'd2);
        @(posedge clk);
        #1;

        // Wider register file: mov r15,r9.
        instr4 = {4'd0, 4'd9, 4'd15, 7'h01};
        instr_valid4 = 1'b1;
        @(posedge clk);
        #1 instr_valid4 = 1'b0;
        @(negedge clk);
        chk("aw4_mov", {11'd0, gp_reg_ie4, reg_l_ctl4, pc_inc4}, {11'd0, 16'h8000, 4'd9, 1'b1});
        @(posedge clk);
        #1;

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
